// File: rtl/ps2_key_decoder.sv
// PS/2 scancode stream to key events, held-direction map and move code.
// Optional: define KEY_REPEAT_FILTER_EN to suppress typematic repeats of held direction keys.
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 5000000,
  parameter int unsigned TO_W           = 23
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_en,
  input  logic [7:0] key_data,
  output logic       key_valid,
  output logic [7:0] keycode,
  output logic       key_make,
  output logic       key_ext,
  output logic [3:0] held,
  output logic [2:0] move
);

  typedef enum logic [2:0] {StIdle, StExt, StBrk, StExtBrk, StSkip} state_e;

  localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [2:0]      skip_q, skip_d;
  logic [TO_W-1:0] to_q, to_d;

  logic       valid_q, valid_d;
  logic [7:0] code_q, code_d;
  logic       make_q, make_d;
  logic       ext_q, ext_d;
  logic [3:0] held_q, held_d;
  logic [2:0] move_q, move_d;

  logic       emit, emit_make, emit_ext;
  logic [2:0] dir;
  logic [3:0] dir_bit;
  logic       suppress;

  function automatic logic [2:0] dir_of(input logic [7:0] code, input logic ext);
    logic [2:0] d;
    d = 3'd0;
    if (ext) begin
      case (code)
        8'h75:   d = 3'd1;
        8'h72:   d = 3'd2;
        8'h6B:   d = 3'd3;
        8'h74:   d = 3'd4;
        default: d = 3'd0;
      endcase
    end else begin
      case (code)
        8'h1D:   d = 3'd1;
        8'h1B:   d = 3'd2;
        8'h1C:   d = 3'd3;
        8'h23:   d = 3'd4;
        default: d = 3'd0;
      endcase
    end
    return d;
  endfunction

  function automatic logic [2:0] prio_of(input logic [3:0] h);
    logic [2:0] d;
    if (h[0])      d = 3'd1;
    else if (h[1]) d = 3'd2;
    else if (h[2]) d = 3'd3;
    else if (h[3]) d = 3'd4;
    else           d = 3'd0;
    return d;
  endfunction

  // Prefix parsing; a byte arriving on the expiry cycle wins over the timeout.
  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    to_d      = to_q;
    emit      = 1'b0;
    emit_make = 1'b0;
    emit_ext  = 1'b0;
    if (key_en) begin
      to_d = '0;
      unique case (state_q)
        StIdle: begin
          case (key_data)
            8'hE0: state_d = StExt;
            8'hF0: state_d = StBrk;
            8'hE1: begin
              state_d = StSkip;
              skip_d  = 3'd7;
            end
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
              state_d = StIdle;
            end
            default: begin
              emit      = 1'b1;
              emit_make = 1'b1;
            end
          endcase
        end
        StExt: begin
          if (key_data == 8'hF0) begin
            state_d = StExtBrk;
          end else begin
            state_d = StIdle;
            if (key_data != 8'h12) begin
              emit      = 1'b1;
              emit_make = 1'b1;
              emit_ext  = 1'b1;
            end
          end
        end
        StBrk: begin
          state_d = StIdle;
          emit    = 1'b1;
        end
        StExtBrk: begin
          state_d = StIdle;
          if (key_data != 8'h12) begin
            emit     = 1'b1;
            emit_ext = 1'b1;
          end
        end
        StSkip: begin
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle) begin
      if (to_q == ToLast) begin
        state_d = StIdle;
        to_d    = '0;
      end else begin
        to_d = to_q + 1'b1;
      end
    end else begin
      to_d = '0;
    end
  end

  always_comb begin
    dir     = dir_of(key_data, emit_ext);
    dir_bit = (dir != 3'd0) ? (4'd1 << (dir - 3'd1)) : 4'd0;
`ifdef KEY_REPEAT_FILTER_EN
    suppress = emit_make && ((held_q & dir_bit) != 4'd0);
`else
    suppress = 1'b0;
`endif
    valid_d = 1'b0;
    code_d  = code_q;
    make_d  = make_q;
    ext_d   = ext_q;
    held_d  = held_q;
    move_d  = move_q;
    if (emit && !suppress) begin
      valid_d = 1'b1;
      code_d  = key_data;
      make_d  = emit_make;
      ext_d   = emit_ext;
      if (dir != 3'd0) begin
        if (emit_make) begin
          held_d = held_q | dir_bit;
          move_d = dir;
        end else begin
          held_d = held_q & ~dir_bit;
          if (move_q == dir) move_d = prio_of(held_d);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      skip_q  <= '0;
      to_q    <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
      make_q  <= 1'b0;
      ext_q   <= 1'b0;
      held_q  <= '0;
      move_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      to_q    <= to_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      make_q  <= make_d;
      ext_q   <= ext_d;
      held_q  <= held_d;
      move_q  <= move_d;
    end
  end

  assign key_valid = valid_q;
  assign keycode   = code_q;
  assign key_make  = make_q;
  assign key_ext   = ext_q;
  assign held      = held_q;
  assign move      = move_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed vector bench for ps2_key_decoder (short timeout for speed).
module tb_ps2_key_decoder;

  localparam int unsigned Tmo = 20;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       key_en = 1'b0;
  logic [7:0] key_data = 8'h00;
  logic       key_valid;
  logic [7:0] keycode;
  logic       key_make;
  logic       key_ext;
  logic [3:0] held;
  logic [2:0] move;

  int checks = 0;
  int errors = 0;

  ps2_key_decoder #(
    .TIMEOUT_CYCLES(Tmo),
    .TO_W          (5)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .key_en   (key_en),
    .key_data (key_data),
    .key_valid(key_valid),
    .keycode  (keycode),
    .key_make (key_make),
    .key_ext  (key_ext),
    .held     (held),
    .move     (move)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic [7:0] code;
    logic       make;
    logic       ext;
    logic [3:0] held;
    logic [2:0] move;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] d, input logic v, input logic [7:0] c, input logic m,
                     input logic e, input logic [3:0] h, input logic [2:0] mv);
    vec_t t;
    t.data = d; t.valid = v; t.code = c; t.make = m; t.ext = e; t.held = h; t.move = mv;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Leaves the caller at the negedge right after the byte's sampling edge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    key_en   = 1'b1;
    key_data = b;
    @(negedge clk);
    key_en   = 1'b0;
  endtask

  task automatic check_event(input string name, input logic [7:0] c, input logic m,
                             input logic e, input logic [3:0] h, input logic [2:0] mv);
    check({name, ".valid"}, 32'(key_valid), 32'd1);
    check({name, ".code"}, 32'(keycode), 32'(c));
    check({name, ".make"}, 32'(key_make), 32'(m));
    check({name, ".ext"}, 32'(key_ext), 32'(e));
    check({name, ".held"}, 32'(held), 32'(h));
    check({name, ".move"}, 32'(move), 32'(mv));
  endtask

  initial begin
    logic rep_v;
`ifdef KEY_REPEAT_FILTER_EN
    rep_v = 1'b0;
`else
    rep_v = 1'b1;
`endif
    // WASD make/break
    add(8'h1C, 1, 8'h1C, 1, 0, 4'b0100, 3'd3);
    add(8'hF0, 0, 8'h00, 0, 0, 4'b0100, 3'd3);
    add(8'h1C, 1, 8'h1C, 0, 0, 4'b0000, 3'd0);
    // Arrow keys, most recent wins, fallback on break
    add(8'hE0, 0, 8'h00, 0, 0, 4'b0000, 3'd0);
    add(8'h75, 1, 8'h75, 1, 1, 4'b0001, 3'd1);
    add(8'hE0, 0, 8'h00, 0, 0, 4'b0001, 3'd1);
    add(8'h74, 1, 8'h74, 1, 1, 4'b1001, 3'd4);
    add(8'hE0, 0, 8'h00, 0, 0, 4'b1001, 3'd4);
    add(8'hF0, 0, 8'h00, 0, 0, 4'b1001, 3'd4);
    add(8'h74, 1, 8'h74, 0, 1, 4'b0001, 3'd1);
    add(8'hE0, 0, 8'h00, 0, 0, 4'b0001, 3'd1);
    add(8'hF0, 0, 8'h00, 0, 0, 4'b0001, 3'd1);
    add(8'h75, 1, 8'h75, 0, 1, 4'b0000, 3'd0);
    // Pause sequence: silent, then a normal make
    add(8'hE1, 0, 8'h00, 0, 0, 4'b0000, 3'd0);
    add(8'h14, 0, 8'h00, 0, 0, 4'b0000, 3'd0);
    add(8'h77, 0, 8'h00, 0, 0, 4'b0000, 3'd0);
    add(8'hE1, 0, 8'h00, 0, 0, 4'b0000, 3'd0);
    add(8'hF0, 0, 8'h00, 0, 0, 4'b0000, 3'd0);
    add(8'h14, 0, 8'h00, 0, 0, 4'b0000, 3'd0);
    add(8'hF0, 0, 8'h00, 0, 0, 4'b0000, 3'd0);
    add(8'h77, 0, 8'h00, 0, 0, 4'b0000, 3'd0);
    add(8'h29, 1, 8'h29, 1, 0, 4'b0000, 3'd0);
    // Ignored bytes and fake shifts
    add(8'hAA, 0, 8'h00, 0, 0, 4'b0000, 3'd0);
    add(8'hFA, 0, 8'h00, 0, 0, 4'b0000, 3'd0);
    add(8'hE0, 0, 8'h00, 0, 0, 4'b0000, 3'd0);
    add(8'h12, 0, 8'h00, 0, 0, 4'b0000, 3'd0);
    add(8'hE0, 0, 8'h00, 0, 0, 4'b0000, 3'd0);
    add(8'hF0, 0, 8'h00, 0, 0, 4'b0000, 3'd0);
    add(8'h12, 0, 8'h00, 0, 0, 4'b0000, 3'd0);
    // Extended non-direction key
    add(8'hE0, 0, 8'h00, 0, 0, 4'b0000, 3'd0);
    add(8'h5A, 1, 8'h5A, 1, 1, 4'b0000, 3'd0);
    // Arrow code without E0 is not a direction
    add(8'h75, 1, 8'h75, 1, 0, 4'b0000, 3'd0);
    // Priority fallback
    add(8'h1D, 1, 8'h1D, 1, 0, 4'b0001, 3'd1);
    add(8'h1B, 1, 8'h1B, 1, 0, 4'b0011, 3'd2);
    add(8'h23, 1, 8'h23, 1, 0, 4'b1011, 3'd4);
    add(8'hF0, 0, 8'h00, 0, 0, 4'b1011, 3'd4);
    add(8'h1D, 1, 8'h1D, 0, 0, 4'b1010, 3'd4);
    add(8'hF0, 0, 8'h00, 0, 0, 4'b1010, 3'd4);
    add(8'h23, 1, 8'h23, 0, 0, 4'b0010, 3'd2);
    add(8'hF0, 0, 8'h00, 0, 0, 4'b0010, 3'd2);
    add(8'h1B, 1, 8'h1B, 0, 0, 4'b0000, 3'd0);
    // Typematic repeats
    add(8'h1D, 1, 8'h1D, 1, 0, 4'b0001, 3'd1);
    add(8'h1D, rep_v, 8'h1D, 1, 0, 4'b0001, 3'd1);
    add(8'h1D, rep_v, 8'h1D, 1, 0, 4'b0001, 3'd1);
    add(8'hF0, 0, 8'h00, 0, 0, 4'b0001, 3'd1);
    add(8'h1D, 1, 8'h1D, 0, 0, 4'b0000, 3'd0);

    repeat (3) @(negedge clk);
    check("rst.valid", 32'(key_valid), 32'd0);
    check("rst.code", 32'(keycode), 32'd0);
    check("rst.make", 32'(key_make), 32'd0);
    check("rst.ext", 32'(key_ext), 32'd0);
    check("rst.held", 32'(held), 32'd0);
    check("rst.move", 32'(move), 32'd0);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      send(vecs[i].data);
      check($sformatf("vec%0d.valid", i), 32'(key_valid), 32'(vecs[i].valid));
      if (vecs[i].valid) begin
        check($sformatf("vec%0d.code", i), 32'(keycode), 32'(vecs[i].code));
        check($sformatf("vec%0d.make", i), 32'(key_make), 32'(vecs[i].make));
        check($sformatf("vec%0d.ext", i), 32'(key_ext), 32'(vecs[i].ext));
      end
      check($sformatf("vec%0d.held", i), 32'(held), 32'(vecs[i].held));
      check($sformatf("vec%0d.move", i), 32'(move), 32'(vecs[i].move));
    end

    // Pulse lasts exactly one cycle
    send(8'h29);
    @(negedge clk);
    check("pulse.one_cycle", 32'(key_valid), 32'd0);

    // Byte arriving on the last cycle before expiry still counts as extended
    send(8'hE0);
    repeat (18) @(negedge clk);
    send(8'h75);
    check_event("to_edge", 8'h75, 1'b1, 1'b1, 4'b0001, 3'd1);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    check_event("to_edge_rel", 8'h75, 1'b0, 1'b1, 4'b0000, 3'd0);

    // Expired prefix: following byte decodes from idle
    send(8'hE0);
    repeat (Tmo + 2) @(negedge clk);
    send(8'h75);
    check_event("timeout", 8'h75, 1'b1, 1'b0, 4'b0000, 3'd0);

    // Reset between F0 and its byte
    send(8'h1B);
    check_event("pre_rst", 8'h1B, 1'b1, 1'b0, 4'b0010, 3'd2);
    send(8'hF0);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("midrst.valid", 32'(key_valid), 32'd0);
    check("midrst.code", 32'(keycode), 32'd0);
    check("midrst.make", 32'(key_make), 32'd0);
    check("midrst.held", 32'(held), 32'd0);
    check("midrst.move", 32'(move), 32'd0);
    send(8'h1B);
    check_event("post_rst", 8'h1B, 1'b1, 1'b0, 4'b0010, 3'd2);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
